// File: rtl/rr_decode_arbiter_pkg.sv
// Shared types and constants for the round-robin decoded-resource arbiter.
package rr_decode_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   localparam logic [0:3]  W_NONE           = 4'b1111;
   localparam int unsigned MAX_HOLD_DEFAULT = 8;

   // Active-low one-hot decode of a requester index onto W[0:3].
   function automatic logic [0:3] sel_to_w(input logic [1:0] s);
      logic [0:3] r;
      r    = W_NONE;
      r[s] = 1'b0;
      return r;
   endfunction

endpackage

// File: rtl/rr_decode_arbiter_if.sv
// Request/grant bundle between the four requesters and the arbiter.
interface rr_decode_arbiter_if;
   logic [0:3] req;
   logic       done;
   logic [0:3] w;
   logic [1:0] sel;
   logic       busy;
   logic       tout;

   modport master (output req, done, input w, sel, busy, tout);
   modport slave  (input req, done, output w, sel, busy, tout);
endinterface

// File: rtl/rr_decode_arbiter_pick.sv
// Round-robin pick: first set request scanning last+1, last+2, ... modulo 4.
module rr_pick (
   input  logic [0:3] req,
   input  logic [1:0] last,
   output logic       valid,
   output logic [1:0] pick
);

   logic [1:0] idx;

   always_comb begin
      valid = 1'b0;
      pick  = '0;
      idx   = '0;
      // off=4 truncates to 0, so the previous grantee is considered last.
      for (int unsigned off = 1; off <= 4; off++) begin
         idx = last + 2'(off);
         if (!valid && req[idx]) begin
            valid = 1'b1;
            pick  = idx;
         end
      end
   end

endmodule

// File: rtl/rr_decode_arbiter.sv
// Four-way round-robin arbiter with bounded hold, driving a registered
// active-low one-hot grant for a 2-to-4 decoded resource.
module rr_decode_arbiter
   import rr_decode_arbiter_pkg::*;
#(
   parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT,
   parameter int unsigned CNT_W    = 4
) (
   input  logic               clk,
   input  logic               rst,
   rr_decode_arbiter_if.slave bus
);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [1:0]         last_q, last_d;
   logic [0:3]         w_q, w_d;
   logic [1:0]         sel_q, sel_d;
   logic               busy_q, busy_d;
   logic               tout_q, tout_d;
   logic               pick_valid;
   logic [1:0]         pick;

   rr_pick u_pick (
      .req   (bus.req),
      .last  (last_q),
      .valid (pick_valid),
      .pick  (pick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         last_q  <= 2'd3;
         w_q     <= W_NONE;
         sel_q   <= '0;
         busy_q  <= 1'b0;
         tout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         w_q     <= w_d;
         sel_q   <= sel_d;
         busy_q  <= busy_d;
         tout_q  <= tout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      w_d     = w_q;
      sel_d   = sel_q;
      busy_d  = busy_q;
      tout_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            w_d    = W_NONE;
            busy_d = 1'b0;
            if (pick_valid) begin
               state_d = ST_GRANT;
               sel_d   = pick;
               w_d     = sel_to_w(pick);
               busy_d  = 1'b1;
               cnt_d   = '0;
               last_d  = pick;
            end
         end
         ST_GRANT: begin
            // Normal release outranks timeout, so a coincident DONE keeps TOUT low.
            if (bus.done || !bus.req[sel_q]) begin
               state_d = ST_RELEASE;
               w_d     = W_NONE;
               busy_d  = 1'b0;
            end else if (cnt_q == CNT_W'(MAX_HOLD - 1)) begin
               state_d = ST_RELEASE;
               w_d     = W_NONE;
               busy_d  = 1'b0;
               tout_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RELEASE: begin
            state_d = ST_IDLE;
            w_d     = W_NONE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
            w_d     = W_NONE;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign bus.w    = w_q;
   assign bus.sel  = sel_q;
   assign bus.busy = busy_q;
   assign bus.tout = tout_q;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Directed bench for rr_decode_arbiter with hand-computed expectations.
module tb_rr_decode_arbiter;

   logic clk;
   logic rst;
   int   tests;
   int   fails;

   rr_decode_arbiter_if bus ();

   rr_decode_arbiter #(
      .MAX_HOLD (8),
      .CNT_W    (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   logic [3:0] wtab [4];

   initial begin
      wtab[0] = 4'b0111;
      wtab[1] = 4'b1011;
      wtab[2] = 4'b1101;
      wtab[3] = 4'b1110;
      tests = 0;
      fails = 0;
      rst = 1'b1;
      bus.req = 4'b0000;
      bus.done = 1'b0;

      tick();
      tick();
      check("rst_w", 8'(bus.w), 8'h0F);
      check("rst_sel", 8'(bus.sel), 8'h00);
      check("rst_busy", 8'(bus.busy), 8'h00);
      check("rst_tout", 8'(bus.tout), 8'h00);
      rst = 1'b0;

      // Reset mid-grant: requester 1 granted, then async reset.
      bus.req = 4'b0100;
      tick();
      check("pre_rst_w", 8'(bus.w), 8'h0B);
      check("pre_rst_busy", 8'(bus.busy), 8'h01);
      #2 rst = 1'b1;
      #1;
      check("async_rst_w", 8'(bus.w), 8'h0F);
      check("async_rst_busy", 8'(bus.busy), 8'h00);
      check("async_rst_sel", 8'(bus.sel), 8'h00);
      bus.req = 4'b0000;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("idle_w", 8'(bus.w), 8'h0F);
         check("idle_sel", 8'(bus.sel), 8'h00);
      end

      // Round-robin with all requests held, DONE in each grant's second cycle.
      bus.req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("rr_w", 8'(bus.w), 8'(wtab[k % 4]));
         check("rr_sel", 8'(bus.sel), 8'(k % 4));
         tick();
         check("rr_w_hold", 8'(bus.w), 8'(wtab[k % 4]));
         bus.done = 1'b1;
         tick();
         bus.done = 1'b0;
         check("rr_gap1", 8'(bus.w), 8'h0F);
         if (k == 4) bus.req = 4'b0000;
         tick();
         check("rr_gap2", 8'(bus.w), 8'h0F);
      end

      // Single request from requester 2, grant lasts 4 cycles.
      bus.req = 4'b0010;
      tick();
      check("single_w", 8'(bus.w), 8'h0D);
      check("single_sel", 8'(bus.sel), 8'h02);
      check("single_busy", 8'(bus.busy), 8'h01);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("single_w_hold", 8'(bus.w), 8'h0D);
         check("single_tout", 8'(bus.tout), 8'h00);
      end
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      bus.req = 4'b0000;
      check("single_rel_w", 8'(bus.w), 8'h0F);
      check("single_rel_busy", 8'(bus.busy), 8'h00);
      check("single_rel_sel", 8'(bus.sel), 8'h02);
      check("single_rel_tout", 8'(bus.tout), 8'h00);
      tick();

      // Timeout: requester 0 holds for MAX_HOLD=8 cycles without DONE.
      bus.req = 4'b1000;
      tick();
      check("to_w", 8'(bus.w), 8'h07);
      for (int i = 1; i < 8; i++) begin
         tick();
         check("to_w_hold", 8'(bus.w), 8'h07);
         check("to_tout_low", 8'(bus.tout), 8'h00);
      end
      tick();
      check("to_rel_w", 8'(bus.w), 8'h0F);
      check("to_tout", 8'(bus.tout), 8'h01);
      check("to_busy", 8'(bus.busy), 8'h00);
      tick();
      check("to_tout_clr", 8'(bus.tout), 8'h00);
      check("to_idle_w", 8'(bus.w), 8'h0F);
      tick();
      check("to_regrant_w", 8'(bus.w), 8'h07);
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      bus.req = 4'b0000;
      tick();

      // DONE coincident with the timeout cycle counts as a normal release.
      bus.req = 4'b0100;
      tick();
      check("sim_w", 8'(bus.w), 8'h0B);
      for (int i = 1; i < 8; i++) begin
         tick();
         check("sim_w_hold", 8'(bus.w), 8'h0B);
      end
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      bus.req = 4'b0000;
      check("sim_rel_w", 8'(bus.w), 8'h0F);
      check("sim_tout", 8'(bus.tout), 8'h00);
      tick();

      // Dropping the grantee's request releases on the next edge.
      bus.req = 4'b0010;
      tick();
      check("drop_w", 8'(bus.w), 8'h0D);
      tick();
      check("drop_w_hold", 8'(bus.w), 8'h0D);
      bus.req = 4'b0000;
      tick();
      check("drop_rel_w", 8'(bus.w), 8'h0F);
      check("drop_tout", 8'(bus.tout), 8'h00);
      tick();

      // Set last=1 via a short grant to requester 1.
      bus.req = 4'b0100;
      tick();
      check("setlast_w", 8'(bus.w), 8'h0B);
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      bus.req = 4'b0000;
      tick();

      // Priority skip: last=1, requesters 0 and 3 -> 3 first, then 0.
      bus.req = 4'b1001;
      tick();
      check("skip_w", 8'(bus.w), 8'h0E);
      check("skip_sel", 8'(bus.sel), 8'h03);
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      tick();
      tick();
      check("skip_next_w", 8'(bus.w), 8'h07);
      check("skip_next_sel", 8'(bus.sel), 8'h00);
      bus.req = 4'b0000;
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
